// File: rtl/fp32_mul_round_if.sv
// fp32_mul_round_if
// Groups the upstream raw-product handshake and the downstream result
// handshake of the FP32 multiplier post-normalise/round/pack stage.
//
// Upstream (master drives, slave receives):
//   in_valid_i, sign_i, exp_sum_i[9:0], mant_i[47:0], cls_a_i[2:0], cls_b_i[2:0]
//   in_ready_o (slave drives)
// Downstream:
//   out_ready_i (master drives)
//   out_valid_o, result_o[31:0], nan_o, infinit_o, overflow_o, underflow_o,
//   inexact_o (slave drives)
// Operand class encoding is {nan, inf, zero}, at most one bit set.
interface fp32_mul_round_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        sign_i;
  logic [9:0]  exp_sum_i;
  logic [47:0] mant_i;
  logic [2:0]  cls_a_i;
  logic [2:0]  cls_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] result_o;
  logic        nan_o;
  logic        infinit_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;

  // Producer of raw products / consumer of results.
  modport master (
    output in_valid_i, sign_i, exp_sum_i, mant_i, cls_a_i, cls_b_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o,
           nan_o, infinit_o, overflow_o, underflow_o, inexact_o
  );

  // The normalise/round/pack stage itself.
  modport slave (
    input  in_valid_i, sign_i, exp_sum_i, mant_i, cls_a_i, cls_b_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o,
           nan_o, infinit_o, overflow_o, underflow_o, inexact_o
  );
endinterface

// File: rtl/fp32_mul_round.sv
// fp32_mul_round
// Post-multiply stage of the FP32 multiplier: takes the raw product (sign,
// biased exponent sum, 48-bit significand product, operand classes),
// normalises it, rounds to nearest-even and packs an IEEE-754 single with
// exception flags. One operation in flight; results are held in HOLD until
// the consumer takes them.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fp32_mul_round_if.slave: upstream raw product + valid/ready,
//           downstream result/flags + valid/ready
module fp32_mul_round (
  input logic             clk,
  input logic             rst_n,
  fp32_mul_round_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    ROUND,
    PACK,
    HOLD
  } state_t;

  state_t state;
  state_t state_next;

  // Captured operation and working values
  logic               sign_q;
  logic signed [9:0]  exp_q;
  logic [47:0]        mant_q;
  logic [2:0]         cls_a_q;
  logic [2:0]         cls_b_q;
  logic [22:0]        frac_q;
  logic               guard_q;
  logic               sticky_q;

  // Registered result and flags
  logic [31:0]        result_q;
  logic               nan_q;
  logic               inf_q;
  logic               ovf_q;
  logic               unf_q;
  logic               inx_q;

  // Rounding and packing intermediates
  logic               round_up;
  logic [24:0]        rounded;
  logic               special_nan;
  logic               any_inf;
  logic               any_zero;
  logic [31:0]        pack_result;
  logic               pack_nan;
  logic               pack_inf;
  logic               pack_ovf;
  logic               pack_unf;
  logic               pack_inx;

  // State register; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a fixed three-step walk from accept to HOLD, then wait
  // for the consumer. Handshake inputs are only looked at in their own state.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.in_valid_i) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = PACK;
      PACK:    state_next = HOLD;
      HOLD:    if (bus.out_ready_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == HOLD);

  // Round-to-nearest-even: bump on guard when either sticky breaks the tie or
  // the lsb is odd. The add is done on the full 24-bit significand so a carry
  // out of the hidden bit signals renormalisation.
  always_comb begin
    round_up = guard_q & (sticky_q | frac_q[0]);
    rounded  = {2'b01, frac_q} + 25'd1;
  end

  // Exception priority: NaN (incl. inf*0) beats inf beats zero beats range.
  // inexact on a normal result reflects the bits lost before rounding.
  always_comb begin
    special_nan = cls_a_q[2] | cls_b_q[2] |
                  (cls_a_q[1] & cls_b_q[0]) | (cls_a_q[0] & cls_b_q[1]);
    any_inf     = cls_a_q[1] | cls_b_q[1];
    any_zero    = cls_a_q[0] | cls_b_q[0];

    pack_result = 32'h0;
    pack_nan    = 1'b0;
    pack_inf    = 1'b0;
    pack_ovf    = 1'b0;
    pack_unf    = 1'b0;
    pack_inx    = 1'b0;

    if (special_nan) begin
      pack_result = 32'h7FC0_0000;
      pack_nan    = 1'b1;
    end else if (any_inf) begin
      pack_result = {sign_q, 8'hFF, 23'h0};
      pack_inf    = 1'b1;
    end else if (any_zero) begin
      pack_result = {sign_q, 31'h0};
    end else if (exp_q >= 10'sd255) begin
      pack_result = {sign_q, 8'hFF, 23'h0};
      pack_ovf    = 1'b1;
      pack_inx    = 1'b1;
    end else if (exp_q <= 10'sd0) begin
      pack_result = {sign_q, 31'h0};
      pack_unf    = 1'b1;
      pack_inx    = 1'b1;
    end else begin
      pack_result = {sign_q, exp_q[7:0], frac_q};
      pack_inx    = guard_q | sticky_q;
    end
  end

  // Datapath: capture on accept, then one step of normalise, round and pack
  // per cycle. Result/flags only change in PACK so they stay put in HOLD and
  // afterwards until the next operation reaches PACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q   <= 1'b0;
      exp_q    <= 10'sd0;
      mant_q   <= 48'h0;
      cls_a_q  <= 3'b000;
      cls_b_q  <= 3'b000;
      frac_q   <= 23'h0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      result_q <= 32'h0;
      nan_q    <= 1'b0;
      inf_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            sign_q  <= bus.sign_i;
            exp_q   <= $signed(bus.exp_sum_i);
            mant_q  <= bus.mant_i;
            cls_a_q <= bus.cls_a_i;
            cls_b_q <= bus.cls_b_i;
          end
        end
        NORM: begin
          // Product of two [1,2) significands lies in [1,4); bit 47 set means
          // it is in [2,4) and needs a one-place shift plus exponent bump.
          if (mant_q[47]) begin
            frac_q   <= mant_q[46:24];
            guard_q  <= mant_q[23];
            sticky_q <= |mant_q[22:0];
            exp_q    <= exp_q + 10'sd1;
          end else begin
            frac_q   <= mant_q[45:23];
            guard_q  <= mant_q[22];
            sticky_q <= |mant_q[21:0];
          end
        end
        ROUND: begin
          if (round_up) begin
            frac_q <= rounded[22:0];
            if (rounded[24]) begin
              exp_q <= exp_q + 10'sd1;
            end
          end
        end
        PACK: begin
          result_q <= pack_result;
          nan_q    <= pack_nan;
          inf_q    <= pack_inf;
          ovf_q    <= pack_ovf;
          unf_q    <= pack_unf;
          inx_q    <= pack_inx;
        end
        HOLD: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.result_o    = result_q;
  assign bus.nan_o       = nan_q;
  assign bus.infinit_o   = inf_q;
  assign bus.overflow_o  = ovf_q;
  assign bus.underflow_o = unf_q;
  assign bus.inexact_o   = inx_q;

endmodule

// File: doc/fp32_mul_round.md
# fp32_mul_round

Post-multiply normalize/round/pack stage for the FP32 multiplier datapath. Consumes the raw product of the multiply stage: sign, biased exponent sum and full 48-bit significand product, plus operand class flags. Produces a correctly rounded (round-to-nearest-even) IEEE-754 single-precision result with exception flags. Valid/ready handshake on both sides; one operation in flight at a time.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  upstream presents a raw product.
- in_ready_o  out  1  block accepts a raw product; high only in IDLE.
- sign_i  in  1  product sign (sign_a ^ sign_b).
- exp_sum_i  in  10  two's-complement exp_a + exp_b - 127; legal range -127..383.
- mant_i  in  48  {1,frac_a} * {1,frac_b}.
- cls_a_i, cls_b_i  in  3 each  {nan, inf, zero}; at most one bit set per operand. Denormal inputs are flagged zero upstream.
- out_valid_o  out  1  result and flags valid.
- out_ready_i  in  1  downstream accepts result.
- result_o  out  32  packed FP32 result.
- nan_o, infinit_o, overflow_o, underflow_o, inexact_o  out  1 each  exception flags, qualified by out_valid_o.

## Operation
- FSM states: IDLE, NORM, ROUND, PACK, HOLD.
- IDLE: on in_valid_i & in_ready_o, register all inputs and go to NORM. Inputs are ignored in every other state.
- NORM:
  - mant[47]=1: frac=mant[46:24], guard=mant[23], sticky=|mant[22:0], exp=exp_sum+1.
  - Otherwise: frac=mant[45:23], guard=mant[22], sticky=|mant[21:0], exp=exp_sum.
- ROUND (RNE):
  - Increment when guard & (sticky | frac[0]).
  - Increment is a 24-bit add on {1,frac}. On carry-out, frac=0 and exp+1.
  - Internal exp is 10-bit signed; no wrap is possible (max 385).
- PACK, first match wins:
  1. Either NaN, or inf×zero → 32'h7FC00000, nan_o=1.
  2. Either inf → {sign, 8'hFF, 23'h0}, infinit_o=1.
  3. Either zero → {sign, 31'h0}, all flags 0.
  4. exp ≥ 255 → {sign, 8'hFF, 23'h0}, overflow_o=1, inexact_o=1.
  5. exp ≤ 0 → {sign, 31'h0}, underflow_o=1, inexact_o=1. No denormal outputs.
  6. Otherwise → {sign, exp[7:0], frac}, inexact_o = guard | sticky (pre-round).
  - All flags not named in the matching case are 0.
- HOLD: out_valid_o=1. On out_valid_o & out_ready_i, go to IDLE.

## Timing
- Reset: state IDLE. result_o=0, all flags 0, out_valid_o=0, in_ready_o=1 (combinational from state).
- Accept at edge E. Transitions: E+1 NORM→ROUND, E+2 ROUND→PACK. At E+3, PACK→HOLD; result and flags are registered and out_valid_o rises.
- Transfer at the first edge ≥ E+4 where out_ready_i=1. out_valid_o falls on that edge; in_ready_o is high the following cycle.
- Minimum initiation interval: 5 cycles.
- In HOLD, result_o and flags are stable regardless of out_ready_i.
- After transfer, result_o and flags keep their value until the next PACK; they are qualified only by out_valid_o.
- out_ready_i is ignored outside HOLD. An early assertion does not shorten latency.
- in_valid_i held high across a transfer: the next accept happens at the edge after the return to IDLE.
- rst_n asserted in any state: immediate return to reset values, and any in-flight operation is discarded.

## Test plan
- 1.5×2.0: sign_i=0, exp_sum_i=128, mant_i=48'h600000000000 → result_o=32'h40400000, all flags 0, out_valid_o rises 3 edges after accept.
- Normalize shift: exp_sum_i=127, mant_i=48'h800000000000 → 32'h40000000, inexact_o=0.
- RNE cases, exp_sum_i=127:
  - mant_i=48'h7FFFFFC00000 → round carry, 32'h40000000, inexact_o=1.
  - mant_i=48'h400000400000 (tie, lsb 0) → 32'h3F800000, inexact_o=1.
- Range: mant_i=48'h400000000000 with
  - exp_sum_i=300, sign_i=1 → 32'hFF800000, overflow_o=1, inexact_o=1.
  - exp_sum_i=-10 → 32'h00000000, underflow_o=1.
- Specials:
  - cls_a_i=inf, cls_b_i=zero → 32'h7FC00000, nan_o=1.
  - cls_a_i=inf, sign_i=1, cls_b_i=none → 32'hFF800000, infinit_o=1.
- Handshake/reset:
  - Hold out_ready_i=0 three cycles in HOLD → result stable, in_ready_o=0, second in_valid_i not taken.
  - Assert rst_n low while in ROUND → all outputs 0, in_ready_o=1, no result emitted.
